// File: rtl/cv32e40p_wake_unit_if.sv
// Sleep-stage / interrupt / debug signal bundle for the WFI wake unit.
// The slave modport is the wake unit; the master modport is whoever drives it.
interface cv32e40p_wake_unit_if;
  logic        fetch_enable_i;
  logic        wfi_insn_i;
  logic [31:0] irq_i;
  logic [31:0] irq_en_i;
  logic        debug_req_i;
  logic        debug_mode_i;
  logic        debug_single_step_i;
  logic        ext_wake_async_i;
  logic        core_sleep_i;
  logic        sleep_cycles_clr_i;
  logic        wake_from_sleep_o;
  logic        debug_wfi_no_sleep_o;
  logic [1:0]  wfi_state_o;
  logic [31:0] sleep_cycles_o;

  modport slave (
    input  fetch_enable_i, wfi_insn_i, irq_i, irq_en_i, debug_req_i, debug_mode_i,
           debug_single_step_i, ext_wake_async_i, core_sleep_i, sleep_cycles_clr_i,
    output wake_from_sleep_o, debug_wfi_no_sleep_o, wfi_state_o, sleep_cycles_o
  );

  modport master (
    output fetch_enable_i, wfi_insn_i, irq_i, irq_en_i, debug_req_i, debug_mode_i,
           debug_single_step_i, ext_wake_async_i, core_sleep_i, sleep_cycles_clr_i,
    input  wake_from_sleep_o, debug_wfi_no_sleep_o, wfi_state_o, sleep_cycles_o
  );
endinterface

// File: rtl/cv32e40p_wake_unit.sv
// WFI sleep/wake controller with a synchronized external wake pin.
// Optional sleep cycle counter is enabled by defining CV32E40P_SLEEP_CNT_EN.
module cv32e40p_wake_unit (
  input logic                 clk_ungated_i,
  input logic                 rst_n,
  cv32e40p_wake_unit_if.slave wake_if
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SLEEP = 2'd1,
    SLEEP      = 2'd2,
    WAKE       = 2'd3
  } wfiState_e;

  wfiState_e state_q, state_d;
  logic      extWakeMeta_q, extWakeSync_q;
  logic      wakeEvent;
  logic      noSleep;
  logic      wfiAccepted;

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      extWakeMeta_q <= 1'b0;
      extWakeSync_q <= 1'b0;
    end else begin
      extWakeMeta_q <= wake_if.ext_wake_async_i;
      extWakeSync_q <= extWakeMeta_q;
    end
  end

  assign wakeEvent   = (|(wake_if.irq_i & wake_if.irq_en_i)) | wake_if.debug_req_i | extWakeSync_q;
  assign noSleep     = wake_if.debug_mode_i | wake_if.debug_single_step_i | wake_if.debug_req_i;
  assign wfiAccepted = wake_if.wfi_insn_i & wake_if.fetch_enable_i & ~noSleep;

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wfiAccepted && wakeEvent) begin
          state_d = WAKE;
        end else if (wfiAccepted) begin
          state_d = WAIT_SLEEP;
        end
      end
      WAIT_SLEEP: begin
        if (wakeEvent) begin
          state_d = WAKE;
        end else if (wake_if.core_sleep_i) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (wakeEvent) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The wake request is live in every state so synchronous sources reach
  // the sleep stage with no added latency; WAKE stretches it by one cycle.
  always_comb begin
    wake_if.wfi_state_o          = state_q;
    wake_if.wake_from_sleep_o    = wakeEvent | (state_q == WAKE);
    wake_if.debug_wfi_no_sleep_o = noSleep;
  end

`ifdef CV32E40P_SLEEP_CNT_EN
  logic [31:0] sleepCnt_q, sleepCnt_d;

  always_comb begin
    sleepCnt_d = sleepCnt_q;
    if (wake_if.sleep_cycles_clr_i) begin
      sleepCnt_d = '0;
    end else if ((state_q == SLEEP) && (sleepCnt_q != 32'hFFFF_FFFF)) begin
      sleepCnt_d = sleepCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      sleepCnt_q <= '0;
    end else begin
      sleepCnt_q <= sleepCnt_d;
    end
  end

  assign wake_if.sleep_cycles_o = sleepCnt_q;
`else
  assign wake_if.sleep_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_cv32e40p_wake_unit.sv
// Directed bench for cv32e40p_wake_unit: vector table plus multi-cycle sequences.
// Counter checks adapt to whether CV32E40P_SLEEP_CNT_EN is defined.
module tb_cv32e40p_wake_unit;

  logic clk_ungated_i = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] expCnt;

  cv32e40p_wake_unit_if wakeIf ();

  cv32e40p_wake_unit dut (
    .clk_ungated_i (clk_ungated_i),
    .rst_n         (rst_n),
    .wake_if       (wakeIf.slave)
  );

  always #5 clk_ungated_i = ~clk_ungated_i;

  typedef struct {
    logic        fetchEn;
    logic        wfi;
    logic [31:0] irq;
    logic [31:0] irqEn;
    logic        dbgReq;
    logic        dbgMode;
    logic        dbgStep;
    logic        expWake;
    logic        expNoSleep;
    logic [1:0]  expState;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    wakeIf.fetch_enable_i      = 1'b0;
    wakeIf.wfi_insn_i          = 1'b0;
    wakeIf.irq_i               = '0;
    wakeIf.irq_en_i            = '0;
    wakeIf.debug_req_i         = 1'b0;
    wakeIf.debug_mode_i        = 1'b0;
    wakeIf.debug_single_step_i = 1'b0;
    wakeIf.ext_wake_async_i    = 1'b0;
    wakeIf.core_sleep_i        = 1'b0;
    wakeIf.sleep_cycles_clr_i  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    wakeIf.fetch_enable_i      = v.fetchEn;
    wakeIf.wfi_insn_i          = v.wfi;
    wakeIf.irq_i               = v.irq;
    wakeIf.irq_en_i            = v.irqEn;
    wakeIf.debug_req_i         = v.dbgReq;
    wakeIf.debug_mode_i        = v.dbgMode;
    wakeIf.debug_single_step_i = v.dbgStep;
  endtask

  task automatic step();
    @(posedge clk_ungated_i);
    @(negedge clk_ungated_i);
  endtask

  task automatic resetDut();
    @(negedge clk_ungated_i);
    clearInputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk_ungated_i);
  endtask

  // Leaves the DUT in SLEEP at a falling edge with core_sleep_i held high.
  task automatic enterSleep(input string tag);
    wakeIf.fetch_enable_i = 1'b1;
    wakeIf.wfi_insn_i     = 1'b1;
    step();
    wakeIf.wfi_insn_i   = 1'b0;
    wakeIf.core_sleep_i = 1'b1;
    #1;
    checkOutput({tag, "_state_wait"}, {30'd0, wakeIf.wfi_state_o}, 32'd1);
    step();
    #1;
    checkOutput({tag, "_state_sleep"}, {30'd0, wakeIf.wfi_state_o}, 32'd2);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[1] = '{1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 1'b1, 32'h8,         32'h8,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};
    vecs[3] = '{1'b1, 1'b1, 32'hF0,        32'h0F,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[4] = '{1'b1, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    vecs[5] = '{1'b1, 1'b1, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[6] = '{1'b1, 1'b1, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[7] = '{1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[8] = '{1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[9] = '{1'b1, 1'b1, 32'h8000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};

    // Reset behaviour: state and counter held, combinational outputs follow inputs.
    clearInputs();
    #2;
    wakeIf.debug_mode_i = 1'b1;
    #1;
    checkOutput("rst_state", {30'd0, wakeIf.wfi_state_o}, 32'd0);
    checkOutput("rst_cnt", wakeIf.sleep_cycles_o, 32'd0);
    checkOutput("rst_nosleep", {31'd0, wakeIf.debug_wfi_no_sleep_o}, 32'd1);
    wakeIf.debug_mode_i   = 1'b0;
    wakeIf.fetch_enable_i = 1'b1;
    wakeIf.wfi_insn_i     = 1'b1;
    wakeIf.irq_i          = 32'h1;
    wakeIf.irq_en_i       = 32'h1;
    #1;
    checkOutput("rst_wake_comb", {31'd0, wakeIf.wake_from_sleep_o}, 32'd1);
    @(posedge clk_ungated_i);
    #1;
    checkOutput("rst_state_held", {30'd0, wakeIf.wfi_state_o}, 32'd0);
    resetDut();

    for (int i = 0; i < 10; i++) begin
      resetDut();
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_wake", i), {31'd0, wakeIf.wake_from_sleep_o}, {31'd0, vecs[i].expWake});
      checkOutput($sformatf("vec%0d_nosleep", i), {31'd0, wakeIf.debug_wfi_no_sleep_o}, {31'd0, vecs[i].expNoSleep});
      step();
      wakeIf.wfi_insn_i = 1'b0;
      #1;
      checkOutput($sformatf("vec%0d_state", i), {30'd0, wakeIf.wfi_state_o}, {30'd0, vecs[i].expState});
    end

    // Basic sleep/wake with irq line 3 after ten cycles in SLEEP.
    resetDut();
    enterSleep("basic");
    repeat (9) step();
    wakeIf.irq_i[3]    = 1'b1;
    wakeIf.irq_en_i[3] = 1'b1;
    #1;
    checkOutput("basic_wake_same_cycle", {31'd0, wakeIf.wake_from_sleep_o}, 32'd1);
    checkOutput("basic_still_sleep", {30'd0, wakeIf.wfi_state_o}, 32'd2);
    step();
    wakeIf.irq_i        = '0;
    wakeIf.core_sleep_i = 1'b0;
    #1;
    checkOutput("basic_state_wake", {30'd0, wakeIf.wfi_state_o}, 32'd3);
    checkOutput("basic_wake_stretch", {31'd0, wakeIf.wake_from_sleep_o}, 32'd1);
`ifdef CV32E40P_SLEEP_CNT_EN
    expCnt = 32'd10;
`else
    expCnt = 32'd0;
`endif
    checkOutput("basic_cnt", wakeIf.sleep_cycles_o, expCnt);
    step();
    #1;
    checkOutput("basic_state_idle", {30'd0, wakeIf.wfi_state_o}, 32'd0);
    checkOutput("basic_wake_low", {31'd0, wakeIf.wake_from_sleep_o}, 32'd0);

    // Pending interrupt at WFI goes straight to WAKE without counting.
    wakeIf.irq_i[0]    = 1'b1;
    wakeIf.irq_en_i[0] = 1'b1;
    wakeIf.wfi_insn_i  = 1'b1;
    step();
    wakeIf.wfi_insn_i = 1'b0;
    wakeIf.irq_i      = '0;
    #1;
    checkOutput("pend_state_wake", {30'd0, wakeIf.wfi_state_o}, 32'd3);
    step();
    #1;
    checkOutput("pend_state_idle", {30'd0, wakeIf.wfi_state_o}, 32'd0);
    checkOutput("pend_cnt", wakeIf.sleep_cycles_o, expCnt);

    // Masked interrupts must not wake; debug request then does.
    resetDut();
    enterSleep("mask");
    wakeIf.irq_i    = 32'hFFFF_FFFF;
    wakeIf.irq_en_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("mask_wake_%0d", c), {31'd0, wakeIf.wake_from_sleep_o}, 32'd0);
      checkOutput($sformatf("mask_state_%0d", c), {30'd0, wakeIf.wfi_state_o}, 32'd2);
      step();
    end
    wakeIf.irq_i       = '0;
    wakeIf.debug_req_i = 1'b1;
    #1;
    checkOutput("dbgwake_comb", {31'd0, wakeIf.wake_from_sleep_o}, 32'd1);
    step();
    wakeIf.debug_req_i  = 1'b0;
    wakeIf.core_sleep_i = 1'b0;
    #1;
    checkOutput("dbgwake_state", {30'd0, wakeIf.wfi_state_o}, 32'd3);

    // External wake pin: two-flop latency, then WAKE and IDLE.
    resetDut();
    enterSleep("ext");
    wakeIf.ext_wake_async_i = 1'b1;
    #1;
    checkOutput("ext_wake_c0", {31'd0, wakeIf.wake_from_sleep_o}, 32'd0);
    step();
    wakeIf.ext_wake_async_i = 1'b0;
    #1;
    checkOutput("ext_wake_c1", {31'd0, wakeIf.wake_from_sleep_o}, 32'd0);
    checkOutput("ext_state_c1", {30'd0, wakeIf.wfi_state_o}, 32'd2);
    step();
    #1;
    checkOutput("ext_wake_c2", {31'd0, wakeIf.wake_from_sleep_o}, 32'd1);
    step();
    wakeIf.core_sleep_i = 1'b0;
    #1;
    checkOutput("ext_state_wake", {30'd0, wakeIf.wfi_state_o}, 32'd3);
    checkOutput("ext_wake_stretch", {31'd0, wakeIf.wake_from_sleep_o}, 32'd1);
    step();
    #1;
    checkOutput("ext_state_idle", {30'd0, wakeIf.wfi_state_o}, 32'd0);
    checkOutput("ext_wake_low", {31'd0, wakeIf.wake_from_sleep_o}, 32'd0);

    // Counter clear during SLEEP, saturation, and reset mid-sleep.
    resetDut();
    enterSleep("cnt");
    repeat (3) step();
    wakeIf.sleep_cycles_clr_i = 1'b1;
    step();
    wakeIf.sleep_cycles_clr_i = 1'b0;
    #1;
    checkOutput("cnt_clear", wakeIf.sleep_cycles_o, 32'd0);
    step();
    #1;
`ifdef CV32E40P_SLEEP_CNT_EN
    checkOutput("cnt_after_clear", wakeIf.sleep_cycles_o, 32'd1);
    dut.sleepCnt_q = 32'hFFFF_FFFE;
    step();
    #1;
    checkOutput("cnt_reach_max", wakeIf.sleep_cycles_o, 32'hFFFF_FFFF);
    repeat (4) step();
    #1;
    checkOutput("cnt_saturate", wakeIf.sleep_cycles_o, 32'hFFFF_FFFF);
`else
    checkOutput("cnt_after_clear", wakeIf.sleep_cycles_o, 32'd0);
`endif
    checkOutput("cnt_state_sleep", {30'd0, wakeIf.wfi_state_o}, 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_state", {30'd0, wakeIf.wfi_state_o}, 32'd0);
    checkOutput("midrst_cnt", wakeIf.sleep_cycles_o, 32'd0);
    #2;
    rst_n = 1'b1;
    wakeIf.core_sleep_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      checkOutput($sformatf("midrst_nowake_%0d", c), {31'd0, wakeIf.wake_from_sleep_o}, 32'd0);
      checkOutput($sformatf("midrst_idle_%0d", c), {30'd0, wakeIf.wfi_state_o}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_wake_unit.md
CV32E40P_WAKE_UNIT -- requirements
Module: cv32e40p_wake_unit

Interface
REQ-001 The block SHALL use clock clk_ungated_i and reset rst_n (asynchronous, active-low); the clock is free-running and never gated.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk_ungated_i  in  1  free-running clock
- rst_n  in  1  async active-low reset
- fetch_enable_i  in  1  sticky fetch enable from the sleep stage
- wfi_insn_i  in  1  one-cycle pulse when a WFI is decoded and accepted
- irq_i  in  32  interrupt lines, synchronous to the clock
- irq_en_i  in  32  per-line enable (mie)
- debug_req_i  in  1  debug request
- debug_mode_i  in  1  core in debug mode
- debug_single_step_i  in  1  single-step active
- ext_wake_async_i  in  1  asynchronous external wake pin
- core_sleep_i  in  1  sleep indication from the sleep stage
- sleep_cycles_clr_i  in  1  clear the sleep cycle counter
- wake_from_sleep_o  out  1  wake request to the sleep stage
- debug_wfi_no_sleep_o  out  1  WFI is not allowed to sleep
- wfi_state_o  out  2  current FSM state encoding
- sleep_cycles_o  out  32  count of cycles spent in SLEEP

Function
REQ-003 ext_wake_async_i SHALL pass through a 2-flop synchronizer (ext_wake_sync); the first-flop input SHALL be the pin itself, and latency pin->ext_wake_sync SHALL be 2 cycles.
REQ-004 wake_event SHALL be (|(irq_i & irq_en_i)) | debug_req_i | ext_wake_sync, combinational.
REQ-005 debug_wfi_no_sleep_o SHALL be debug_mode_i | debug_single_step_i | debug_req_i, combinational, in every state.
REQ-006 FSM states and encodings SHALL be IDLE=0, WAIT_SLEEP=1, SLEEP=2, WAKE=3; wfi_state_o SHALL equal the state register.
REQ-007 IDLE transitions SHALL be evaluated in this order:
- wfi_insn_i & fetch_enable_i & !debug_wfi_no_sleep_o & wake_event -> WAKE
- wfi_insn_i & fetch_enable_i & !debug_wfi_no_sleep_o -> WAIT_SLEEP
- otherwise -> stay in IDLE
REQ-008 In IDLE, wfi_insn_i SHALL be ignored whenever fetch_enable_i=0 or debug_wfi_no_sleep_o=1.
REQ-009 WAIT_SLEEP transitions SHALL be: wake_event -> WAKE; else core_sleep_i -> SLEEP; else stay. wake_event SHALL have priority when both inputs are high.
REQ-010 SLEEP transitions SHALL be: wake_event -> WAKE; else stay.
REQ-011 WAKE SHALL last exactly one cycle and then go unconditionally to IDLE.
REQ-012 wake_from_sleep_o SHALL be wake_event | (state==WAKE), in all states; this gives 0-cycle latency for synchronous sources and a 1-cycle stretch in WAKE.
REQ-013 wfi_insn_i received in any state other than IDLE SHALL be ignored.

Reset
REQ-014 While rst_n=0, the block SHALL hold: state=IDLE, synchronizer flops=0, and counter=0.
REQ-015 Reset values of the outputs SHALL be: wfi_state_o=0, sleep_cycles_o=0; wake_from_sleep_o and debug_wfi_no_sleep_o follow their inputs combinationally.
REQ-016 Reset asserted mid-sleep SHALL return the block to IDLE immediately (asynchronously); after deassertion no WAKE pulse SHALL be generated.

Configuration
REQ-017 Macro CV32E40P_SLEEP_CNT_EN SHALL control the sleep cycle counter.
- Defined: sleep_cycles_o SHALL increment by 1 for each cycle the state is SLEEP, saturate at 0xFFFF_FFFF (no wrap), and clear to 0 on sleep_cycles_clr_i. Clear SHALL win over a simultaneous increment, and the counter SHALL retain its value outside SLEEP.
- Undefined: sleep_cycles_o SHALL be constant 0, no counter flops SHALL exist, and sleep_cycles_clr_i SHALL be ignored.

Verification
REQ-018 Basic sleep/wake: fetch_enable_i=1, wfi_insn_i pulse, core_sleep_i=1 next cycle, 10 cycles later irq_i[3]=1 with irq_en_i[3]=1.
- Required: state sequence 0->1->2->3->0.
- Required: wake_from_sleep_o=1 in the same cycle irq_i[3] rises.
- Required: sleep_cycles_o=10 with CV32E40P_SLEEP_CNT_EN defined.
REQ-019 Masked interrupt: while in SLEEP, irq_i=0xFFFF_FFFF with irq_en_i=0.
- Required: state stays 2 and wake_from_sleep_o=0.
REQ-020 Debug blocks WFI: debug_mode_i=1 when wfi_insn_i pulses.
- Required: debug_wfi_no_sleep_o=1 and state stays 0.
REQ-021 External wake: in SLEEP, ext_wake_async_i rises.
- Required: wake_from_sleep_o=1 exactly 2 cycles later, then state 3 followed by state 0.
REQ-022 Pending interrupt at WFI: wfi_insn_i pulses while irq_i[0]=1 and irq_en_i[0]=1.
- Required: IDLE->WAKE directly (state 3 for one cycle), and sleep_cycles_o unchanged.
REQ-023 Counter corner cases (CV32E40P_SLEEP_CNT_EN defined):
- Counter preloaded to 0xFFFF_FFFE, then SLEEP for 5 cycles -> sleep_cycles_o=0xFFFF_FFFF (saturated).
- sleep_cycles_clr_i asserted during SLEEP -> sleep_cycles_o=0 on the next cycle.
- rst_n pulsed during SLEEP -> state 0 and sleep_cycles_o=0, with no WAKE pulse afterwards.
